// File: rtl/vga_pkg.sv
// Shared timing constants, pixel record and scan FSM encoding for the VGA back end.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [14:0] rgb;
  } pixel_t;

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of tagged pixels; head is combinational from the read pointer.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  logic   pop_i,
  input  pixel_t data_i,
  output pixel_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  pixel_t      mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA timing generator and raster scanout that locks a tagged pixel stream to the beam position.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_rgb,
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  output logic [4:0]  vga_r,
  output logic [4:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        locked,
  output logic        err_underflow,
  output logic        err_slip,
  input  logic        clr_err
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  scan_state_t state_q, state_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [14:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic        uf_q, uf_d, slip_q, slip_d;

  pixel_t      in_pix, head;
  logic        fifo_full, fifo_empty, pop;
  logic        active, at_origin, head_origin, head_hit;
  logic        show, set_uf, set_slip;

  assign in_pix = '{x: in_x, y: in_y, rgb: in_rgb};
  assign in_ready = !fifo_full;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (in_valid),
    .pop_i   (pop),
    .data_i  (in_pix),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign active      = (h_q < H_ACT) && (v_q < V_ACT);
  assign at_origin   = (h_q == '0) && (v_q == '0);
  assign head_origin = !fifo_empty && (head.x == '0) && (head.y == '0);
  assign head_hit    = !fifo_empty && (head.x == h_q) && (head.y == v_q);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // WAIT drains stale entries every clk; only a head of (0,0) waits for the frame start.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    show     = 1'b0;
    set_uf   = 1'b0;
    set_slip = 1'b0;
    case (state_q)
      WAIT: begin
        if (!fifo_empty && !head_origin) begin
          pop = 1'b1;
        end else if (pix_ce && at_origin && head_origin) begin
          pop     = 1'b1;
          show    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (pix_ce && active) begin
          if (fifo_empty) begin
            set_uf  = 1'b1;
            state_d = WAIT;
          end else if (!head_hit) begin
            set_slip = 1'b1;
            state_d  = WAIT;
          end else begin
            pop  = 1'b1;
            show = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    rgb_d  = rgb_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    de_d   = de_q;
    uf_d   = set_uf   | (uf_q   & ~clr_err);
    slip_d = set_slip | (slip_q & ~clr_err);
    if (pix_ce) begin
      de_d  = active;
      hs_d  = !((h_q >= HS_BEG) && (h_q < HS_END));
      vs_d  = !((v_q >= VS_BEG) && (v_q < VS_END));
      rgb_d = show ? head.rgb : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      h_q     <= '0;
      v_q     <= '0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      uf_q    <= 1'b0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      uf_q    <= uf_d;
      slip_q  <= slip_d;
    end
  end

  assign vga_r         = rgb_q[14:10];
  assign vga_g         = rgb_q[9:5];
  assign vga_b         = rgb_q[4:0];
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_de        = de_q;
  assign locked        = (state_q == RUN);
  assign err_underflow = uf_q;
  assign err_slip      = slip_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken 16x11 raster (8x6 active) to keep frames short.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int H_A = 8;
  localparam int V_A = 6;
  localparam int H_T = 16;
  localparam int V_T = 11;
  localparam int F_T = H_T * V_T;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_rgb = '0;
  logic [9:0]  in_x = '0;
  logic [9:0]  in_y = '0;
  logic [4:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de;
  logic        locked, err_underflow, err_slip;
  logic        clr_err = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc;
  pixel_t pending[$];
  bit acc = 1'b0;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rgb(in_rgb), .in_x(in_x), .in_y(in_y),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .locked(locked), .err_underflow(err_underflow), .err_slip(err_slip),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Beam position reference: outputs at a negedge belong to position ncyc-1.
  always @(posedge clk or negedge rst) begin
    if (!rst) ncyc <= 0;
    else if (pix_ce) ncyc <= ncyc + 1;
  end

  // Upstream source: presents the queue head and retires it once accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        pending.delete();
        acc = 1'b0;
        in_valid = 1'b0;
      end else begin
        if (acc && pending.size() > 0) pending.delete(0);
        if (pending.size() > 0) begin
          in_valid = 1'b1;
          in_x = pending[0].x;
          in_y = pending[0].y;
          in_rgb = pending[0].rgb;
        end else begin
          in_valid = 1'b0;
        end
        acc = in_valid && in_ready;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] grad(input int x, input int y);
    logic [4:0] bx, by, bb;
    bx = 5'(x);
    by = 5'(y);
    bb = 5'(x + y + 1);
    return {bx, by, bb};
  endfunction

  function automatic int pos_idx();
    if (ncyc < 1) return -1;
    return (ncyc - 1) % F_T;
  endfunction

  function automatic int pos_h();
    int p;
    p = pos_idx();
    return (p < 0) ? -1 : p % H_T;
  endfunction

  function automatic int pos_v();
    int p;
    p = pos_idx();
    return (p < 0) ? -1 : p / H_T;
  endfunction

  task automatic push_pix(input int x, input int y, input logic [14:0] rgb);
    pixel_t p;
    p.x = 10'(x);
    p.y = 10'(y);
    p.rgb = rgb;
    pending.push_back(p);
  endtask

  // Queue raster pixels 0..upto, leaving out index skip (-1 for none).
  task automatic queue_frame(input int upto, input int skip);
    for (int i = 0; i < H_A * V_A; i++)
      if (i <= upto && i != skip) push_pix(i % H_A, i / H_A, grad(i % H_A, i / H_A));
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((pos_h() != h || pos_v() != v) && n < 400);
    chk("wait_pos", pos_idx(), v * H_T + h);
  endtask

  task automatic check_frame(input string tag, input bit lk);
    int h, v, bs, br, bl, den;
    logic e_de, e_hs, e_vs;
    logic [14:0] e_rgb;
    bs = 0; br = 0; bl = 0; den = 0;
    for (int i = 0; i < F_T; i++) begin
      @(negedge clk);
      h = pos_h();
      v = pos_v();
      e_de = (h < H_A) && (v < V_A);
      e_hs = !(h >= 10 && h < 13);
      e_vs = !(v >= 7 && v < 9);
      e_rgb = (lk && e_de) ? grad(h, v) : 15'd0;
      if (vga_hs !== e_hs || vga_vs !== e_vs || vga_de !== e_de) bs++;
      if ({vga_r, vga_g, vga_b} !== e_rgb) br++;
      if (locked !== lk) bl++;
      if (vga_de === 1'b1) den++;
    end
    chk({tag, "_sync_bad"}, bs, 0);
    chk({tag, "_rgb_bad"}, br, 0);
    chk({tag, "_lock_bad"}, bl, 0);
    chk({tag, "_de_count"}, den, H_A * V_A);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_hs"}, vga_hs, 1);
    chk({tag, "_vs"}, vga_vs, 1);
    chk({tag, "_de"}, vga_de, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_uf"}, err_underflow, 0);
    chk({tag, "_slip"}, err_slip, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Idle raster after reset: sync/de timing only, black, unlocked.
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b1;
    wait_pos(15, 10);
    check_frame("idle", 1'b0);

    // Full-frame stream: lock at next frame start, then underflow only when active resumes.
    do_reset();
    wait_pos(4, 3);
    queue_frame(47, -1);
    queue_frame(47, -1);
    wait_pos(15, 10);
    check_frame("strm1", 1'b1);
    check_frame("strm2", 1'b1);
    chk("blank_uf", err_underflow, 0);
    chk("blank_slip", err_slip, 0);
    chk("blank_locked", locked, 1);
    @(negedge clk);
    chk("eos_uf", err_underflow, 1);
    chk("eos_locked", locked, 0);
    chk("eos_de", vga_de, 1);

    // Stale preload discarded while pix_ce is held low; FIFO then fills and back-pressures.
    do_reset();
    wait_pos(4, 3);
    pix_ce = 1'b0;
    push_pix(5, 5, 15'h7fff);
    push_pix(6, 5, 15'h7fff);
    queue_frame(47, -1);
    queue_frame(27, -1);
    repeat (20) @(negedge clk);
    chk("full_ready", in_ready, 0);
    chk("hold_de", vga_de, 1);
    chk("hold_locked", locked, 0);
    pix_ce = 1'b1;
    wait_pos(15, 10);
    check_frame("pre", 1'b1);
    chk("pre_slip", err_slip, 0);
    wait_pos(3, 3);
    chk("stall_pre_r", vga_r, 3);
    @(negedge clk);
    chk("stall_uf", err_underflow, 1);
    chk("stall_locked", locked, 0);
    chk("stall_rgb", {vga_r, vga_g, vga_b}, 0);
    repeat (100) @(negedge clk);
    queue_frame(47, -1);
    queue_frame(47, -1);
    wait_pos(15, 10);
    check_frame("relock", 1'b1);
    chk("sticky_uf", err_underflow, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_uf", err_underflow, 0);

    // Missing pixel (4,2): slip with clr_err held on the same edge, then relock.
    do_reset();
    wait_pos(4, 3);
    queue_frame(47, 2 * H_A + 4);
    queue_frame(47, -1);
    queue_frame(47, -1);
    wait_pos(3, 2);
    chk("slip_pre_locked", locked, 1);
    chk("slip_pre_r", vga_r, 3);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("slip_set", err_slip, 1);
    chk("slip_locked", locked, 0);
    chk("slip_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("slip_uf", err_underflow, 0);
    wait_pos(15, 10);
    check_frame("slip_relock", 1'b1);
    chk("slip_sticky", err_slip, 1);

    // Asynchronous reset mid-line while locked.
    wait_pos(3, 3);
    chk("mid_locked", locked, 1);
    #2 rst = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_pos(4, 3);
    queue_frame(47, -1);
    wait_pos(15, 10);
    check_frame("post_rst", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
